// File: rtl/seq_divider_if.sv
// Request/result interface of the sequential divider: operands in, quotient/remainder out.
// Macro-free; the signed option lives entirely in seq_divider.
interface seq_divider_if #(
   parameter int width_p = 32
);
   logic               start;
   logic               div_signed;
   logic [width_p-1:0] dividend;
   logic [width_p-1:0] divisor;
   logic               ready;
   logic               done;
   logic [width_p-1:0] quotient;
   logic [width_p-1:0] remainder;

   // Handshake: a request is taken on the clk edge where start=1 and ready=1, and operands
   // are sampled on that edge only. done pulses for one cycle when quotient/remainder are
   // fresh. Results hold until the next accepted request completes.
   modport master (
      output start, div_signed, dividend, divisor,
      input  ready, done, quotient, remainder
   );

   modport slave (
      input  start, div_signed, dividend, divisor,
      output ready, done, quotient, remainder
   );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider producing one quotient bit per cycle.
// Optional signed (two's complement) division is enabled by defining MULDIV_SIGNED_EN.
module seq_divider #(
   parameter int width_p = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   seq_divider_if.slave    bus,
   output logic [1:0]      state_dbg
);
   localparam int cnt_w = $clog2(width_p + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [width_p:0]   a;
   logic [width_p-1:0] q;
   logic [width_p-1:0] m;
   logic [cnt_w-1:0]   count;
   logic [width_p-1:0] quo_r;
   logic [width_p-1:0] rem_r;

   logic               div_zero;
   logic               last_iter;
   logic               ge;
   logic [width_p:0]   a_sh;
   logic [width_p:0]   a_sub;
   logic [width_p:0]   a_nxt;
   logic [width_p-1:0] q_nxt;
   logic [width_p-1:0] mag_dividend;
   logic [width_p-1:0] mag_divisor;
   logic [width_p-1:0] quo_fin;
   logic [width_p-1:0] rem_fin;

   assign div_zero  = (bus.divisor == '0);
   assign last_iter = (count == cnt_w'(width_p - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = div_zero ? S_DONE : S_ITER;
         S_ITER:  if (last_iter) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ready = (state == S_IDLE);
      bus.done  = (state == S_DONE);
      state_dbg = state;
   end

   assign bus.quotient  = quo_r;
   assign bus.remainder = rem_r;

   // One restoring step: shift {A,Q} left, trial-subtract M, keep the difference if it fits.
   always_comb begin
      a_sh  = {a[width_p-1:0], q[width_p-1]};
      a_sub = a_sh - {1'b0, m};
      ge    = (a_sh >= {1'b0, m});
      a_nxt = ge ? a_sub : a_sh;
      q_nxt = {q[width_p-2:0], ge};
   end

   // The guard bit is always 0 between steps since A < M after every restore.
   logic unused_guard;
   assign unused_guard = a[width_p];

`ifdef MULDIV_SIGNED_EN
   logic neg_q;
   logic neg_r;
   logic sgn_dividend;
   logic sgn_divisor;

   always_comb begin
      sgn_dividend = bus.div_signed & bus.dividend[width_p-1];
      sgn_divisor  = bus.div_signed & bus.divisor[width_p-1];
      mag_dividend = sgn_dividend ? -bus.dividend : bus.dividend;
      mag_divisor  = sgn_divisor  ? -bus.divisor  : bus.divisor;
      quo_fin      = neg_q ? -q_nxt : q_nxt;
      rem_fin      = neg_r ? -a_nxt[width_p-1:0] : a_nxt[width_p-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (state == S_IDLE && bus.start) begin
         neg_q <= sgn_dividend ^ sgn_divisor;
         neg_r <= sgn_dividend;
      end
   end
`else
   logic unused_div_signed;
   assign unused_div_signed = bus.div_signed;

   always_comb begin
      mag_dividend = bus.dividend;
      mag_divisor  = bus.divisor;
      quo_fin      = q_nxt;
      rem_fin      = a_nxt[width_p-1:0];
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a     <= '0;
         q     <= '0;
         m     <= '0;
         count <= '0;
         quo_r <= '0;
         rem_r <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  a     <= '0;
                  q     <= mag_dividend;
                  m     <= mag_divisor;
                  count <= '0;
                  // Divide-by-zero skips iteration; the raw dividend is returned untouched.
                  if (div_zero) begin
                     quo_r <= '1;
                     rem_r <= bus.dividend;
                  end
               end
            end
            S_ITER: begin
               a     <= a_nxt;
               q     <= q_nxt;
               count <= count + cnt_w'(1);
               if (last_iter) begin
                  quo_r <= quo_fin;
                  rem_r <= rem_fin;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases with literal results plus random
// operations checked every cycle against a division model built on plain / and %.
module tb_seq_divider;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] state_dbg;

  seq_divider_if #(.width_p(W)) bus ();

  seq_divider #(.width_p(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // ---------------- model state ----------------
  int cyc = 0;            // index of the current cycle (bumped at each posedge)
  int done_cyc = -1;      // cycle in which the model expects done=1
  int acc_cyc = 0;        // cycle right after the last accepted start edge
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0] held_q = '0;
  logic [W-1:0] held_r = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sgn);
    logic [63:0] qq;
    logic [63:0] rr;
    longint sa;
    longint sb;
    if (b == 0) return {{W{1'b1}}, a};
    qq = 64'(a / b);
    rr = 64'(a % b);
`ifdef MULDIV_SIGNED_EN
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = 64'(sa / sb);
      rr = 64'(sa % sb);
    end
`else
    sa = 0;
    sb = longint'(sgn);
    sa = sa + sb;
`endif
    return {qq[W-1:0], rr[W-1:0]};
  endfunction

  // Acceptance model: start is taken at the end of any cycle after the previous done cycle.
  always @(posedge clk) begin
    if (reset_n && bus.start && cyc > done_cyc) begin
      done_cyc = cyc + ((bus.divisor == 0) ? 1 : W + 1);
      exp_q.push_back(ref_div(bus.dividend, bus.divisor, bus.div_signed));
      acc_cyc = cyc + 1;
    end
    cyc = cyc + 1;
  end

  always @(negedge reset_n) begin
    done_cyc = -1;
    exp_q.delete();
    held_q = '0;
    held_r = '0;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (reset_n && cyc == done_cyc) begin
        if (exp_q.size() == 0) check("sb_underflow", 64'd0, 64'd1);
        else {held_q, held_r} = exp_q.pop_front();
      end
      check("ready", 64'(bus.ready), 64'(reset_n ? (cyc > done_cyc) : 1'b1));
      check("done", 64'(bus.done), 64'(reset_n && cyc == done_cyc));
      check("quotient", 64'(bus.quotient), 64'(held_q));
      check("remainder", 64'(bus.remainder), 64'(held_r));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cyc > done_cyc) && n < 200);
    if (!(cyc > done_cyc)) check("issue_wait", 64'd0, 64'd1);
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    bus.div_signed = sgn;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.dividend = $urandom;
    bus.divisor = $urandom;
    bus.div_signed = 1'($urandom_range(0, 1));
  endtask

  // Waits for done; optionally throws ignored start pulses while the divider is busy.
  task automatic wait_done(input bit junk, output int rel);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      bus.start = junk && (cyc < done_cyc) && ($urandom_range(0, 3) == 0);
      if (bus.start) begin
        bus.dividend = $urandom;
        bus.divisor = $urandom;
      end
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    rel = cyc - acc_cyc + 1;
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn, input logic [W-1:0] lq, input logic [W-1:0] lr,
                          input int llat);
    int rel;
    issue(a, b, sgn);
    wait_done(1'b0, rel);
    check({name, "_lat"}, 64'(rel), 64'(llat));
    check({name, "_q"}, 64'(bus.quotient), 64'(lq));
    check({name, "_r"}, 64'(bus.remainder), 64'(lr));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int rel;
    int nd;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bus.start = 1'b0;
    bus.div_signed = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_q", 64'(bus.quotient), 64'd0);
    check("rst_r", 64'(bus.remainder), 64'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    chk_en = 1'b1;

    // Model pins against hand-computed values.
    check("ref_100_7", 64'(ref_div(32'd100, 32'd7, 1'b0)), {32'd14, 32'd2});
    check("ref_5_0", 64'(ref_div(32'd5, 32'd0, 1'b0)), {32'hFFFFFFFF, 32'd5});

    directed("t1", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33);
    directed("t6", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 33);
    @(negedge clk);
    check("t6_ready_after", 64'(bus.ready), 64'd1);
    directed("t2", 32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1);
    directed("t3a", 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 33);
    directed("t3b", 32'd3, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd3, 33);
`ifdef MULDIV_SIGNED_EN
    directed("t5a", 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    directed("t5b", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 33);
    directed("t5z", 32'hFFFFFFF9, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1);
`else
    directed("t5u", 32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'd1, 33);
`endif

    // Busy start in cycle 10 must be ignored.
    issue(32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor = 32'd3;
    wait_done(1'b0, rel);
    check("t4_lat", 64'(rel), 64'd33);
    check("t4_q", 64'(bus.quotient), 64'd14);
    check("t4_r", 64'(bus.remainder), 64'd2);

    // Reset in cycle 15 aborts the divide with no done pulse afterwards.
    issue(32'd100, 32'd7, 1'b0);
    repeat (14) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t4r_ready", 64'(bus.ready), 64'd1);
    check("t4r_done", 64'(bus.done), 64'd0);
    check("t4r_q", 64'(bus.quotient), 64'd0);
    check("t4r_r", 64'(bus.remainder), 64'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("t4r_no_done", 64'(nd), 64'd0);

    // Randomized traffic, with back-to-back requests and ignored busy starts.
    for (int i = 0; i < 80; i++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = '0;
        1, 2, 3: b = 32'($urandom_range(1, 15));
        4:       b = $urandom_range(0, 1) ? 32'hFFFFFFFF : 32'd1;
        5: begin
          a = 32'h80000000;
          b = 32'hFFFFFFFF;
        end
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 100));
      issue(a, b, 1'($urandom_range(0, 1)));
      wait_done(1'($urandom_range(0, 1)), rel);
      check("rnd_lat", 64'(rel), 64'((b == 0) ? 1 : W + 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
